// File: rtl/pe_array_pkg.sv
// pe_array_pkg: shared opcodes, FSM states and status-word layout for pe_array_instruction.
package pe_array_pkg;

    localparam logic [2:0] OpClear     = 3'd0;
    localparam logic [2:0] OpSendW     = 3'd1;
    localparam logic [2:0] OpSendI     = 3'd2;
    localparam logic [2:0] OpSendO     = 3'd3;
    localparam logic [2:0] OpGetResult = 3'd4;
    localparam logic [2:0] OpStatus    = 3'd5;

    typedef enum logic [1:0] {sIdle, sIssue, sWaitRes, sDone} peState;

    localparam int StatusErrBit     = 16;
    localparam int StatusTimeoutBit = 17;
    localparam int StatusCountLsb   = 24;
    localparam int StatusCountWidth = 8;

    localparam logic [31:0] TimeoutWord = 32'hDEAD_BEEF;

    function automatic logic isSend(input logic [2:0] op);
        return op == OpSendW || op == OpSendI || op == OpSendO;
    endfunction

endpackage

// File: rtl/pe_lane_issue.sv
// pe_lane_issue: per-lane pending mask for one send stream; lanes drop out as they handshake.
module pe_lane_issue
    import pe_array_pkg::*;
#(
    parameter int NumLanes = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                load,
    input  logic [NumLanes-1:0] loadMask,
    input  logic                flush,
    input  logic [NumLanes-1:0] ack,
    output logic [NumLanes-1:0] pending,
    output logic                pendingEmpty
);

    logic [NumLanes-1:0] nextPending;

    assign nextPending  = pending & ~ack;
    // Empty as seen after this cycle's handshakes, so the FSM can leave ISSUE on the last one.
    assign pendingEmpty = ~|nextPending;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            pending <= '0;
        else if (en)
            pending <= flush ? '0 : load ? loadMask : nextPending;

endmodule

// File: rtl/pe_array_instruction.sv
// pe_array_instruction: Nios II multi-cycle custom instruction driving a row of PE lanes.
// Define PE_ARRAY_TIMEOUT_EN to abort stalled ISSUE/WAIT_RES after TimeoutCycles cycles.
module pe_array_instruction
    import pe_array_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int NumLanes      = 4,
    parameter int LaneSelWidth  = 2,
    parameter int TimeoutCycles = 1024
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clk_en,
    input  logic                          start,
    input  logic [2:0]                    n,
    input  logic [DataWidth-1:0]          dataa,
    input  logic [DataWidth-1:0]          datab,
    output logic                          done,
    output logic [DataWidth-1:0]          result,
    output logic [NumLanes-1:0]           w_valid,
    output logic [NumLanes-1:0]           i_valid,
    output logic [NumLanes-1:0]           o_valid,
    input  logic [NumLanes-1:0]           w_rdy,
    input  logic [NumLanes-1:0]           i_rdy,
    input  logic [NumLanes-1:0]           o_rdy,
    output logic [DataWidth-1:0]          w_data,
    output logic [DataWidth-1:0]          i_data,
    output logic [DataWidth-1:0]          o_data,
    input  logic [NumLanes-1:0]           res_valid,
    output logic [NumLanes-1:0]           res_rdy,
    input  logic [NumLanes*DataWidth-1:0] res_data,
    output logic                          lane_sclr
);

    peState                         state;
    logic [2:0]                     opReg;
    logic [DataWidth-1:0]           aReg;
    logic [NumLanes-1:0]            selMaskReg;
    logic                           doneReg;
    logic                           sclrReg;
    logic [DataWidth-1:0]           resultReg;
    logic                           errSticky;
    logic                           timeoutSticky;
    logic [StatusCountWidth-1:0]    opCount;

    logic [LaneSelWidth-1:0]        inSel;
    logic                           inBcast;
    logic [31:0]                    inSelWide;
    logic                           inBad;
    logic [NumLanes-1:0]            inMask;
    logic                           unusedDatab;

    logic [NumLanes-1:0]            pending;
    logic                           pendingEmpty;
    logic [NumLanes-1:0]            streamRdy;
    logic [NumLanes-1:0]            ack;
    logic                           inIssue;
    logic                           resHit;
    logic [DataWidth-1:0]           resWord;
    logic [DataWidth-1:0]           statusWord;
    logic                           timedOut;

    assign inSel       = datab[LaneSelWidth-1:0];
    assign inBcast     = datab[DataWidth-1];
    assign inSelWide   = 32'(inSel);
    assign inMask      = inBcast ? '1 : NumLanes'(1) << inSel;
    assign unusedDatab = ^datab[DataWidth-2:LaneSelWidth];
    // GET ignores the broadcast flag, so its lane select must always be in range.
    assign inBad       = n > OpStatus
                      || ((isSend(n) && !inBcast) || n == OpGetResult) && inSelWide >= NumLanes;

    assign inIssue   = state == sIssue;
    assign streamRdy = opReg == OpSendW ? w_rdy : opReg == OpSendI ? i_rdy : o_rdy;
    assign ack       = inIssue ? pending & streamRdy : '0;
    assign w_valid   = inIssue && opReg == OpSendW ? pending : '0;
    assign i_valid   = inIssue && opReg == OpSendI ? pending : '0;
    assign o_valid   = inIssue && opReg == OpSendO ? pending : '0;
    assign w_data    = aReg;
    assign i_data    = aReg;
    assign o_data    = aReg;
    assign res_rdy   = state == sWaitRes ? selMaskReg : '0;
    assign resHit    = |(res_valid & res_rdy);
    assign done      = doneReg;
    assign result    = resultReg;
    assign lane_sclr = sclrReg;

    always_comb begin
        resWord = '0;
        for (int k = 0; k < NumLanes; k++)
            if (selMaskReg[k]) resWord = res_data[k*DataWidth +: DataWidth];
    end

    always_comb begin
        statusWord = '0;
        statusWord[NumLanes-1:0] = res_valid;
        statusWord[StatusErrBit] = errSticky;
        statusWord[StatusTimeoutBit] = timeoutSticky;
        statusWord[StatusCountLsb +: StatusCountWidth] = opCount;
    end

`ifdef PE_ARRAY_TIMEOUT_EN
    localparam int ToWidth = $clog2(TimeoutCycles + 1);
    logic [ToWidth-1:0] toCnt;
    assign timedOut = toCnt == ToWidth'(TimeoutCycles);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            toCnt <= '0;
        else if (clk_en)
            toCnt <= (state == sIssue || state == sWaitRes) && !timedOut ? toCnt + 1'b1 : '0;
`else
    localparam int unusedTimeout = TimeoutCycles;
    assign timedOut = 1'b0;
`endif

    pe_lane_issue #(.NumLanes(NumLanes)) laneIssue (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (clk_en),
        .load         (state == sIdle && start && !inBad && isSend(n)),
        .loadMask     (inMask),
        .flush        (inIssue && timedOut && !pendingEmpty),
        .ack          (ack),
        .pending      (pending),
        .pendingEmpty (pendingEmpty)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state         <= sIdle;
            opReg         <= '0;
            aReg          <= '0;
            selMaskReg    <= '0;
            doneReg       <= 1'b0;
            sclrReg       <= 1'b0;
            resultReg     <= '0;
            errSticky     <= 1'b0;
            timeoutSticky <= 1'b0;
            opCount       <= '0;
        end else if (clk_en) begin
            doneReg   <= 1'b0;
            sclrReg   <= 1'b0;
            resultReg <= '0;
            case (state)
                sIdle:
                    if (start) begin
                        opReg      <= n;
                        aReg       <= dataa;
                        selMaskReg <= NumLanes'(1) << inSel;
                        if (inBad) begin
                            state     <= sDone;
                            doneReg   <= 1'b1;
                            errSticky <= 1'b1;
                        end else if (n == OpClear) begin
                            state         <= sDone;
                            doneReg       <= 1'b1;
                            sclrReg       <= 1'b1;
                            errSticky     <= 1'b0;
                            timeoutSticky <= 1'b0;
                            opCount       <= '0;
                        end else if (n == OpStatus) begin
                            state     <= sDone;
                            doneReg   <= 1'b1;
                            resultReg <= statusWord;
                        end else
                            state <= n == OpGetResult ? sWaitRes : sIssue;
                    end
                sIssue:
                    if (pendingEmpty) begin
                        state   <= sDone;
                        doneReg <= 1'b1;
                        opCount <= opCount + 1'b1;
                    end else if (timedOut) begin
                        state         <= sDone;
                        doneReg       <= 1'b1;
                        resultReg     <= DataWidth'(TimeoutWord);
                        timeoutSticky <= 1'b1;
                    end
                sWaitRes:
                    if (resHit) begin
                        state     <= sDone;
                        doneReg   <= 1'b1;
                        resultReg <= resWord;
                    end else if (timedOut) begin
                        state         <= sDone;
                        doneReg       <= 1'b1;
                        resultReg     <= DataWidth'(TimeoutWord);
                        timeoutSticky <= 1'b1;
                    end
                sDone:
                    state <= sIdle;
            endcase
        end

endmodule

// File: tb/tb_pe_array_instruction.sv
// tb_pe_array_instruction: randomized transactions checked against a per-lane timing model.
module tb_pe_array_instruction;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         clk_en = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   n = '0;
    logic [31:0]  dataa = '0;
    logic [31:0]  datab = '0;
    logic         done;
    logic [31:0]  result;
    logic [3:0]   w_valid, i_valid, o_valid;
    logic [3:0]   w_rdy = '0, i_rdy = '0, o_rdy = '0;
    logic [31:0]  w_data, i_data, o_data;
    logic [3:0]   res_valid = '0;
    logic [3:0]   res_rdy;
    logic [127:0] res_data = '0;
    logic         lane_sclr;

    int checks = 0;
    int errors = 0;
    int mOpCount = 0;
    bit mErr = 1'b0;

    pe_array_instruction dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_en    (clk_en),
        .start     (start),
        .n         (n),
        .dataa     (dataa),
        .datab     (datab),
        .done      (done),
        .result    (result),
        .w_valid   (w_valid),
        .i_valid   (i_valid),
        .o_valid   (o_valid),
        .w_rdy     (w_rdy),
        .i_rdy     (i_rdy),
        .o_rdy     (o_rdy),
        .w_data    (w_data),
        .i_data    (i_data),
        .o_data    (o_data),
        .res_valid (res_valid),
        .res_rdy   (res_rdy),
        .res_data  (res_data),
        .lane_sclr (lane_sclr)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic checkQuiet(input string tag);
        checkVal({tag, "_done"}, 32'(done), 32'd0);
        checkVal({tag, "_result"}, result, 32'd0);
        checkVal({tag, "_valids"}, 32'({w_valid, i_valid, o_valid, res_rdy}), 32'd0);
        checkVal({tag, "_sclr"}, 32'(lane_sclr), 32'd0);
    endtask

    // Each pending lane k becomes ready d[k] cycles into the wait; done follows the slowest one.
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int d[4];
        int sel, maxD, doneC, j;
        bit bcast, send;
        logic [3:0] mask, snap, expV, rdy, rv;
        logic [31:0] expRes;
        sel   = int'(b[1:0]);
        bcast = b[31];
        send  = op >= 3'd1 && op <= 3'd3;
        mask  = bcast ? 4'hF : 4'(1 << sel);
        maxD  = 0;
        for (int k = 0; k < 4; k++) begin
            d[k] = $urandom_range(0, 3);
            if (mask[k] && d[k] > maxD) maxD = d[k];
            res_data[k*32 +: 32] = $urandom;
        end
        snap      = 4'($urandom);
        res_valid = snap;
        w_rdy     = 4'($urandom);
        i_rdy     = 4'($urandom);
        o_rdy     = 4'($urandom);
        start = 1'b1;
        n     = op;
        dataa = a;
        datab = b;
        @(negedge clk);
        checkVal("idle_done", 32'(done), 32'd0);
        expRes = 32'd0;
        if (op == 3'd5) expRes = {mOpCount[7:0], 6'd0, 1'b0, mErr, 12'd0, snap};
        if (op == 3'd4) expRes = res_data[sel*32 +: 32];
        doneC = send ? 2 + maxD : op == 3'd4 ? 2 + d[sel] : 1;
        if (op > 3'd5) mErr = 1'b1;
        if (op == 3'd0) begin
            mErr = 1'b0;
            mOpCount = 0;
        end
        if (send) mOpCount = (mOpCount + 1) % 256;
        nextCycle;
        start = 1'b0;
        n     = 3'($urandom);
        dataa = $urandom;
        datab = $urandom;
        for (int c = 1; c <= doneC; c++) begin
            j    = c - 1;
            expV = '0;
            rdy  = 4'($urandom);
            rv   = 4'($urandom);
            for (int k = 0; k < 4; k++) begin
                if (mask[k] && j <= d[k]) expV[k] = 1'b1;
                if (mask[k] && j < d[k]) rdy[k] = 1'b0;
                if (mask[k] && j == d[k]) rdy[k] = 1'b1;
            end
            if (op == 3'd4) rv[sel] = j >= d[sel];
            w_rdy     = op == 3'd1 ? rdy : 4'($urandom);
            i_rdy     = op == 3'd2 ? rdy : 4'($urandom);
            o_rdy     = op == 3'd3 ? rdy : 4'($urandom);
            res_valid = rv;
            @(negedge clk);
            checkVal("w_valid", 32'(w_valid), 32'(op == 3'd1 && c < doneC ? expV : 4'd0));
            checkVal("i_valid", 32'(i_valid), 32'(op == 3'd2 && c < doneC ? expV : 4'd0));
            checkVal("o_valid", 32'(o_valid), 32'(op == 3'd3 && c < doneC ? expV : 4'd0));
            checkVal("res_rdy", 32'(res_rdy), 32'(op == 3'd4 && c < doneC ? 4'(1 << sel) : 4'd0));
            checkVal("done", 32'(done), 32'(c == doneC));
            checkVal("lane_sclr", 32'(lane_sclr), 32'(c == doneC && op == 3'd0));
            checkVal("result", result, c == doneC ? expRes : 32'd0);
            if (send && c < doneC) checkVal("stream_data", op == 3'd1 ? w_data : op == 3'd2 ? i_data : o_data, a);
            nextCycle;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkQuiet("reset");
        reset_n = 1'b1;
        nextCycle;

        // Directed plan items first, then randomized traffic.
        runOp(3'd1, 32'h5, 32'd2);
        runOp(3'd2, $urandom, 32'h8000_0000);
        runOp(3'd4, 32'd0, 32'd1);
        runOp(3'd3, $urandom, 32'd3);
        runOp(3'd6, $urandom, $urandom);
        runOp(3'd5, 32'd0, 32'd0);
        runOp(3'd0, 32'd0, 32'd0);
        runOp(3'd5, 32'd0, 32'd0);

        // Reset while a unicast send is stalled.
        w_rdy = '0;
        start = 1'b1;
        n     = 3'd1;
        dataa = 32'h5;
        datab = 32'd1;
        nextCycle;
        start = 1'b0;
        @(negedge clk);
        checkVal("stall_w_valid", 32'(w_valid), 32'h2);
        nextCycle;
        @(negedge clk);
        checkVal("stall_w_valid2", 32'(w_valid), 32'h2);
        reset_n = 1'b0;
        #1;
        checkQuiet("midreset");
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        mOpCount = 0;
        mErr     = 1'b0;
        runOp(3'd1, $urandom, 32'd0);
        runOp(3'd5, 32'd0, 32'd0);

        // clk_en low stretches the DONE pulse and ignores start.
        start = 1'b1;
        n     = 3'd0;
        nextCycle;
        start  = 1'b0;
        clk_en = 1'b0;
        @(negedge clk);
        checkVal("freeze_done", 32'(done), 32'd1);
        checkVal("freeze_sclr", 32'(lane_sclr), 32'd1);
        nextCycle;
        @(negedge clk);
        checkVal("freeze_done_hold", 32'(done), 32'd1);
        checkVal("freeze_sclr_hold", 32'(lane_sclr), 32'd1);
        clk_en = 1'b1;
        nextCycle;
        @(negedge clk);
        checkVal("freeze_release", 32'(done), 32'd0);
        mOpCount = 0;
        mErr     = 1'b0;
        clk_en = 1'b0;
        start  = 1'b1;
        n      = 3'd5;
        nextCycle;
        start  = 1'b0;
        clk_en = 1'b1;
        @(negedge clk);
        checkVal("gated_start", 32'(done), 32'd0);
        nextCycle;
        @(negedge clk);
        checkVal("gated_start2", 32'(done), 32'd0);
        nextCycle;

        for (int t = 0; t < 300; t++) begin
            int r;
            r = $urandom_range(0, 9);
            runOp(r > 7 ? 3'($urandom_range(1, 3)) : 3'(r), $urandom, $urandom);
        end
        runOp(3'd5, 32'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_array_instruction.md
Name: pe_array_instruction

Overview:
- Nios II multi-cycle custom-instruction controller for a parametrised row of NumLanes convolution PE/accumulator lanes.
- Latches opcode and operands on start and routes weight, image and partial-sum words to one selected lane or broadcasts them to all lanes, using per-lane valid/ready handshakes.
- Collects accumulator results from a selected lane and reports a status word.
- done is registered and has variable latency, so lanes that are not ready stall the CPU instead of losing data.

Parameters:
- DataWidth, 32, width of dataa/datab/result and of every lane data bus.
- NumLanes, 4, number of PE lanes (1..16).
- LaneSelWidth, 2, width of the lane-select field datab[LaneSelWidth-1:0].
- TimeoutCycles, 1024, stall limit used only when PE_ARRAY_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- clk_en  in  1  when low, all registers hold and start is ignored.
- start  in  1  one-cycle custom-instruction strobe.
- n  in  3  opcode.
- dataa  in  DataWidth  payload word.
- datab  in  DataWidth  [LaneSelWidth-1:0] is the lane select; bit DataWidth-1 is the broadcast flag.
- done  out  1  one-cycle completion pulse.
- result  out  DataWidth  valid only while done=1, otherwise 0.
- w_valid, i_valid, o_valid  out  NumLanes  per-lane send valids.
- w_rdy, i_rdy, o_rdy  in  NumLanes  per-lane send readies.
- w_data, i_data, o_data  out  DataWidth  shared payload bus per stream, driven from the latched dataa.
- res_valid  in  NumLanes  per-lane result valid.
- res_rdy  out  NumLanes  per-lane result ready.
- res_data  in  NumLanes*DataWidth  lane k occupies bits [k*DataWidth +: DataWidth].
- lane_sclr  out  1  one-cycle synchronous clear pulse to all lanes.

Behaviour:
- Reset (reset_n=0, asynchronous), including mid-operation:
  - State goes to IDLE.
  - done, result, all valids, res_rdy, lane_sclr, sticky bits and op_count all go to 0.
- Opcodes:
  - 0 CLEAR
  - 1 SEND_W
  - 2 SEND_I
  - 3 SEND_O
  - 4 GET_RESULT
  - 5 STATUS
  - 6 and 7 are illegal.
- Operand capture: on start&&clk_en in IDLE, latch n, dataa and datab. start arriving in any other state is ignored.
- States and transitions: IDLE, ISSUE, WAIT_RES, DONE.
  - CLEAR goes IDLE→DONE. lane_sclr=1 in the DONE cycle. Clears sticky bits and op_count.
  - SEND goes IDLE→ISSUE.
    - Pending mask = all lanes if broadcast, else one-hot of the selected lane.
    - The stream's valid[k] = pending[k]. pending[k] clears on valid[k]&&rdy[k]; lanes drop out independently.
    - When pending is 0 after the cycle's update → DONE. op_count increments (8-bit, wraps at 255→0).
  - GET goes IDLE→WAIT_RES. res_rdy[sel]=1 only in WAIT_RES. On res_valid[sel]&&res_rdy[sel], latch res_data lane sel → DONE. Broadcast flag is ignored for GET.
  - STATUS goes IDLE→DONE with result fields:
    - [NumLanes-1:0] = res_valid snapshot taken at capture.
    - [16] = error sticky.
    - [17] = timeout sticky.
    - [31:24] = op_count.
    - All other bits 0.
  - Illegal opcode, or selected lane ≥ NumLanes (non-broadcast): go to DONE with result=0 and set the error sticky bit. No lane is touched.
  - DONE: done=1 for exactly one cycle with result driven, then → IDLE.
- Latency (start at cycle T):
  - CLEAR, STATUS and illegal opcodes: done at T+1.
  - SEND or GET with ready lanes: done at T+2. Each stall cycle adds one.
- Boundary conditions:
  - Broadcast with all lanes ready in the first ISSUE cycle completes in one ISSUE cycle.
  - A lane that deasserts rdy after its own handshake has no effect.
  - clk_en=0 freezes the state, pending mask and the pulse timing of done and lane_sclr.

Optional Feature:
- Macro: PE_ARRAY_TIMEOUT_EN.
- Defined:
  - A counter runs in ISSUE and WAIT_RES.
  - After TimeoutCycles cycles in the same state, all valids and res_rdy drop, the state goes to DONE with result=32'hDEAD_BEEF, and the timeout sticky bit is set.
- Undefined: no counter, the block waits forever, and status bit 17 reads 0.

Decomposition:
- Package pe_array_pkg holds:
  - opcode localparams;
  - state encoding;
  - status bit positions (lane mask, error, timeout, op_count field);
  - the timeout sentinel value.
- Sub-module pe_lane_issue: the pending-mask register with load and per-lane clear, and a pending_empty output. It is instantiated once per send stream, or once and muxed by opcode.

Test Plan:
- Unicast SEND_W: start with n=1, dataa=0x00000005, datab=2, all w_rdy=1 → w_valid=4'b0100 for 1 cycle, w_data=5, done at T+2, result=0.
- Broadcast SEND_I: datab=0x80000000, i_rdy=4'b0101, then 4'b1111 after 3 cycles → i_valid goes 1111→1010 (held 3 cycles)→0000, done one cycle after the last handshake.
- GET_RESULT: datab=1, res_valid[1] rises 4 cycles after start, res_data lane1=0x0000002A → res_rdy[1] is high only during WAIT_RES, done with result=0x2A at T+6.
- STATUS after two SENDs and an n=6 → result[31:24]=2, bit16=1. CLEAR then STATUS → bit16=0, op_count=0, lane_sclr pulses once.
- Reset mid-ISSUE: reset_n low while w_valid is high → all outputs read 0 immediately. After release, a new SEND completes normally.
- With PE_ARRAY_TIMEOUT_EN defined and TimeoutCycles=16: SEND_O to lane 3 with o_rdy=0 → done at T+18 with result=0xDEADBEEF, and STATUS shows bit17=1.
